// File: rtl/sram_bist_pkg.sv
// Shared types, FSM state encoding and address/data pattern helpers for the SRAM BIST.
package sram_bist_pkg;

    typedef logic [31:0] Ram_addr_t;
    typedef logic [31:0] Word_t;

    localparam int unsigned IDX_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_OP,
        WR_GAP,
        RD_OP,
        RD_CHK,
        DONE
    } state_t;

    // Byte address of word idx; wraps at the address width.
    function automatic Ram_addr_t pattern_addr(Ram_addr_t base, logic [IDX_W-1:0] idx);
        return base + Ram_addr_t'({idx, 2'b00});
    endfunction

    function automatic Word_t pattern_data(Ram_addr_t addr, Word_t seed, logic inv);
        Word_t d;
        d = seed ^ Word_t'(addr);
        return inv ? ~d : d;
    endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Read-back comparison with saturating mismatch counter and first-failure capture.
module sram_bist_checker
    import sram_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        check_en,
    input  Ram_addr_t   addr,
    input  Word_t       expected,
    input  Word_t       actual,
    output logic [15:0] fail_count,
    output Ram_addr_t   first_fail_addr,
    output Word_t       first_fail_data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (clear) begin
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (check_en && (actual != expected)) begin
            if (fail_count != '1)
                fail_count <= fail_count + 16'd1;
            if (fail_count == '0) begin
                first_fail_addr <= addr;
                first_fail_data <= actual;
            end
        end
    end

endmodule

// File: rtl/sram_bist.sv
// SRAM write/read-back BIST. Define SRAM_BIST_INV_PASS_EN to add a second pass
// with inverted data before completion.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 256,
    parameter Ram_addr_t   BASE_ADDR  = '0,
    parameter Word_t       SEED       = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output Ram_addr_t   bus_addr,
    output logic        read_op,
    output logic        write_op,
    output Word_t       bus_data_write,
    input  Word_t       bus_data_read,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output Ram_addr_t   first_fail_addr,
    output Word_t       first_fail_data
);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             clear;
    logic             last;
    logic             busy_s;
    Ram_addr_t        cur_addr;
    Word_t            cur_data;

`ifdef SRAM_BIST_INV_PASS_EN
    logic inv, inv_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inv <= 1'b0;
        else      inv <= inv_n;
    end
`else
    logic inv;
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    assign last     = (idx == IDX_W'(WORD_COUNT - 1));
    assign busy_s   = (state == WR_OP) || (state == WR_GAP) ||
                      (state == RD_OP) || (state == RD_CHK);
    assign cur_addr = pattern_addr(BASE_ADDR, idx);
    assign cur_data = pattern_data(cur_addr, SEED, inv);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        clear   = 1'b0;
`ifdef SRAM_BIST_INV_PASS_EN
        inv_n   = inv;
`endif
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    idx_n   = '0;
                    state_n = WR_OP;
`ifdef SRAM_BIST_INV_PASS_EN
                    inv_n   = 1'b0;
`endif
                end
            end
            WR_OP:  state_n = WR_GAP;
            WR_GAP: begin
                if (last) begin
                    idx_n   = '0;
                    state_n = RD_OP;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = WR_OP;
                end
            end
            RD_OP:  state_n = RD_CHK;
            RD_CHK: begin
                if (!last) begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = RD_OP;
                end else begin
`ifdef SRAM_BIST_INV_PASS_EN
                    if (!inv) begin
                        inv_n   = 1'b1;
                        idx_n   = '0;
                        state_n = WR_OP;
                    end else begin
                        state_n = DONE;
                    end
`else
                    state_n = DONE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides any advance computed above for this cycle.
        if (busy_s && abort) begin
            state_n = IDLE;
            idx_n   = '0;
`ifdef SRAM_BIST_INV_PASS_EN
            inv_n   = 1'b0;
`endif
        end
    end

    assign write_op       = (state == WR_OP);
    assign read_op        = (state == RD_OP);
    assign bus_addr       = (write_op || read_op) ? cur_addr : '0;
    assign bus_data_write = write_op ? cur_data : '0;
    assign busy           = busy_s;
    assign done           = (state == DONE);
    assign pass           = done && (fail_count == '0);

    sram_bist_checker u_checker (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .check_en        ((state == RD_CHK) && !abort),
        .addr            (cur_addr),
        .expected        (cur_data),
        .actual          (bus_data_read),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_data (first_fail_data)
    );

endmodule

// File: tb/tb_sram_bist.sv
// Scoreboard bench for sram_bist with a behavioural SRAM responder and fault injection.
module tb_sram_bist;
    import sram_bist_pkg::*;

    localparam int unsigned N = 4;
`ifdef SRAM_BIST_INV_PASS_EN
    localparam int unsigned PASSES = 2;
`else
    localparam int unsigned PASSES = 1;
`endif
    localparam int unsigned RUN_CYCLES = 4 * N * PASSES;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    Ram_addr_t   bus_addr;
    logic        read_op, write_op;
    Word_t       bus_data_write;
    Word_t       bus_data_read;
    logic        busy, done, pass;
    logic [15:0] fail_count;
    Ram_addr_t   first_fail_addr;
    Word_t       first_fail_data;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned proto_viol = 0;

    typedef struct packed { Ram_addr_t addr; Word_t data; } wr_t;
    typedef struct packed { logic pass; logic [15:0] fc; Ram_addr_t ffa; Word_t ffd; } res_t;

    wr_t   wr_q[$];
    res_t  res_q[$];
    Word_t mem[N];
    Word_t corrupt[N];
    Word_t pat[N] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C};

    sram_bist #(.WORD_COUNT(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .bus_addr        (bus_addr),
        .read_op         (read_op),
        .write_op        (write_op),
        .bus_data_write  (bus_data_write),
        .bus_data_read   (bus_data_read),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_data (first_fail_data)
    );

    always #5 clk = ~clk;

    // Responder: stores writes with an optional corruption mask, returns reads one cycle later.
    always @(posedge clk) begin
        if (write_op) mem[bus_addr[3:2]] <= bus_data_write ^ corrupt[bus_addr[3:2]];
        bus_data_read <= read_op ? mem[bus_addr[3:2]] : '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic done_q = 1'b0;
    logic strobe_q = 1'b0;
    wr_t  ew;
    res_t er;

    always @(negedge clk) begin
        if (read_op && write_op) proto_viol++;
        if ((read_op || write_op) && strobe_q) proto_viol++;
        strobe_q = read_op || write_op;
        if (write_op) begin
            if (wr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, none expected", bus_addr, bus_data_write);
            end else begin
                ew = wr_q.pop_front();
                check("write_addr", bus_addr, ew.addr);
                check("write_data", bus_data_write, ew.data);
            end
        end
        if (done && !done_q) begin
            if (res_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got done=1, none expected");
            end else begin
                er = res_q.pop_front();
                check("pass", pass, er.pass);
                check("fail_count", fail_count, er.fc);
                check("first_fail_addr", first_fail_addr, er.ffa);
                check("first_fail_data", first_fail_data, er.ffd);
            end
        end
        done_q = done;
    end

    task automatic push_writes(input int unsigned passes_n, input int unsigned words);
        for (int unsigned p = 0; p < passes_n; p++)
            for (int unsigned i = 0; i < words; i++)
                wr_q.push_back('{addr: Ram_addr_t'(4 * i), data: (p != 0) ? ~pat[i] : pat[i]});
    endtask

    // Full run from the posedge+1 phase; optional start pulse while busy must be ignored.
    task automatic run(input res_t exp, input bit restart_mid);
        int unsigned cyc;
        push_writes(PASSES, N);
        res_q.push_back(exp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < RUN_CYCLES + 20) begin
            @(posedge clk); #1;
            cyc++;
            start = restart_mid && (cyc == 5);
        end
        start = 1'b0;
        check("done_latency", cyc, RUN_CYCLES);
        @(posedge clk); #1;
        check("done_held", done, 1'b1);
    endtask

    initial begin
        int unsigned cyc;
        for (int i = 0; i < N; i++) corrupt[i] = '0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_strobes", {read_op, write_op}, 2'b00);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_fail_count", fail_count, 16'h0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Clean run, with a start pulse issued mid-run.
        run('{pass: 1'b1, fc: 16'd0, ffa: 32'h0, ffd: 32'h0}, 1'b1);

        // Low byte of word at address 8 corrupted.
        corrupt[2] = 32'h0000_00FF;
        run('{pass: 1'b0, fc: 16'(PASSES), ffa: 32'h8, ffd: 32'hA5A5_00F7}, 1'b0);

        // Words at 4 and 12 corrupted.
        corrupt[2] = '0;
        corrupt[1] = 32'h0000_FF00;
        corrupt[3] = 32'h0000_0001;
        run('{pass: 1'b0, fc: 16'(2 * PASSES), ffa: 32'h4, ffd: 32'hA5A5_FF04}, 1'b0);
        for (int i = 0; i < N; i++) corrupt[i] = '0;

        // Reset asserted while the write to address 4 is on the bus.
        wr_q.push_back('{addr: 32'h0, data: pat[0]});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(write_op && bus_addr == 32'h4) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_wr4", {write_op, bus_addr}, {1'b1, 32'h4});
        rst = 1'b0;
        #1;
        check("rstmid_strobes", {read_op, write_op}, 2'b00);
        check("rstmid_busy_done_pass", {busy, done, pass}, 3'b000);
        check("rstmid_bus", {bus_addr, bus_data_write}, 64'h0);
        check("rstmid_fail_count", fail_count, 16'h0);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_release_idle", {busy, done}, 2'b00);

        // Abort during RD_OP of word 2 (address 8).
        push_writes(1, N);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(read_op && bus_addr == 32'h8) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_rd8", {read_op, bus_addr}, {1'b1, 32'h8});
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {busy, done, pass}, 3'b000);
        check("abort_strobes", {read_op, write_op}, 2'b00);
        @(posedge clk); #1;
        check("abort_stays_idle", busy, 1'b0);

        run('{pass: 1'b1, fc: 16'd0, ffa: 32'h0, ffd: 32'h0}, 1'b0);

        check("protocol_violations", proto_viol, 0);
        check("writes_drained", wr_q.size(), 0);
        check("results_drained", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_bist.md
SRAM_BIST -- requirements
Module: sram_bist

Interface
REQ-001 Parameter WORD_COUNT, default 256, number of 32-bit words tested (legal 1..65536).
REQ-002 Parameter BASE_ADDR, default 0, first byte address tested; 4-byte aligned.
REQ-003 Parameter SEED, default 32'hA5A5_0000, pattern seed.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a test run.
REQ-007 abort  input  1  cancel the run in progress.
REQ-008 bus_addr  output  Ram_addr_t  byte address presented to the SRAM bus responder.
REQ-009 read_op  output  1  read strobe to the responder.
REQ-010 write_op  output  1  write strobe to the responder.
REQ-011 bus_data_write  output  Word_t  write data.
REQ-012 bus_data_read  input  Word_t  read data, valid the cycle after read_op.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  run completed; held until next accepted start.
REQ-015 pass  output  1  done with zero mismatches.
REQ-016 fail_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-017 first_fail_addr  output  Ram_addr_t  address of first mismatch.
REQ-018 first_fail_data  output  Word_t  data read at first mismatch.

Function
REQ-019 Pattern for word i: addr(i) = BASE_ADDR + 4*i, truncated to Ram_addr_t width (wraps); data(i) = SEED XOR zero-extended addr(i).
REQ-020 States: IDLE, WR_OP, WR_GAP, RD_OP, RD_CHK, DONE.
REQ-021 IDLE: start=1 clears fail_count/first_fail_*/done/pass, sets i=0, goes to WR_OP.
REQ-022 WR_OP: write_op=1, bus_addr=addr(i), bus_data_write=data(i) for exactly one cycle, then WR_GAP.
REQ-023 WR_GAP: both strobes 0; i<WORD_COUNT-1 -> i+1, WR_OP; else i=0, RD_OP.
REQ-024 RD_OP: read_op=1, bus_addr=addr(i) for one cycle, then RD_CHK.
REQ-025 RD_CHK: strobes 0; bus_data_read compared to data(i); mismatch increments fail_count (saturating) and, on first mismatch only, captures first_fail_addr/first_fail_data.
REQ-026 RD_CHK: i<WORD_COUNT-1 -> i+1, RD_OP; else DONE.
REQ-027 DONE: done=1, pass=(fail_count==0), busy=0; start=1 restarts as in REQ-021.
REQ-028 read_op and write_op never both 1; never 1 on consecutive cycles.
REQ-029 Run length: exactly 4*WORD_COUNT cycles from start-accept edge to done=1.
REQ-030 start while busy ignored.
REQ-031 abort while busy: next cycle IDLE, strobes 0, done=0, pass=0; fail/capture registers keep values; abort has priority over same-cycle state advance.
REQ-032 abort and start same cycle in IDLE/DONE: start wins.
REQ-033 busy=1 in WR_OP, WR_GAP, RD_OP, RD_CHK, and inverted-phase states.

Reset
REQ-034 rst=0 asynchronously forces IDLE, i=0, and all outputs to 0, including mid-run.
REQ-035 Counters and capture registers reset only by rst and accepted start.

Configuration
REQ-036 Macro SRAM_BIST_INV_PASS_EN defined: after first RD_CHK of last word, a second write/read pass with data(i) inverted runs before DONE (run = 8*WORD_COUNT cycles); undefined: single pass only, REQ-029 timing.

Structure
REQ-037 Shared package holds the state enum and the pattern function; Ram_addr_t/Word_t come from existing shared defines.
REQ-038 One sub-module sram_bist_checker: comparison, saturating counter, first-fail capture.

Verification
REQ-039 WORD_COUNT=4, correct responder: start -> writes A5A50000,A5A50004,A5A50008,A5A5000C to addrs 0,4,8,12; done at cycle 16; pass=1, fail_count=0.
REQ-040 Responder memory byte at addr 8 corrupted after write -> fail_count=1, first_fail_addr=8, pass=0.
REQ-041 Two corrupted words (4 and 12) -> fail_count=2, first_fail_addr=4.
REQ-042 abort during RD_OP of word 2 -> IDLE next cycle, done=0; new start reruns fully to pass=1.
REQ-043 rst low mid-WR_OP -> strobes 0 immediately, all outputs 0; start during busy produces no restart.
REQ-044 With SRAM_BIST_INV_PASS_EN, WORD_COUNT=4: second pass writes 5A5AFFFF at addr 0; done at cycle 32.
